// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath.
// No valid/ready here: instr must be stable from IF through ID, Zero is sampled in EX, strobes are single-cycle levels.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        Zero;
  logic        loadPC;
  logic        PCSrc;
  logic        ALUSrc;
  logic [3:0]  ALUCtrl;
  logic        RegWrite;
  logic        MemToReg;
  logic        MemRead;
  logic        MemWrite;

  modport master (
    input  instr, Zero,
    output loadPC, PCSrc, ALUSrc, ALUCtrl, RegWrite, MemToReg, MemRead, MemWrite
  );

  modport slave (
    output instr, Zero,
    input  loadPC, PCSrc, ALUSrc, ALUCtrl, RegWrite, MemToReg, MemRead, MemWrite
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset controller: IF/ID/EX/MEM/WB FSM, decode latched on ID->EX,
// per-instruction control strobes and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LW, C_SW, C_BEQ, C_ILL
  } class_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  state_t     state_q, state_d;
  class_t     cls_q, dec_cls;
  logic [3:0] alu_q, dec_alu;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       alt;
  logic       is_r;
  logic       unused_bits;

  assign opcode      = bus.instr[6:0];
  assign f3          = bus.instr[14:12];
  assign alt         = bus.instr[30];
  assign is_r        = (opcode == OP_R);
  assign unused_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // Decoder only matters on the ID->EX edge; its result is latched there.
  always_comb begin
    dec_cls = C_ILL;
    dec_alu = ALU_ADD;
    case (opcode)
      OP_R, OP_I: begin
        dec_cls = is_r ? C_R : C_I;
        case (f3)
          3'b000:  dec_alu = (is_r && alt) ? ALU_SUB : ALU_ADD;
          3'b001:  dec_alu = ALU_SLL;
          3'b010:  dec_alu = ALU_SLT;
          3'b100:  dec_alu = ALU_XOR;
          3'b101:  dec_alu = alt ? ALU_SRA : ALU_SRL;
          3'b110:  dec_alu = ALU_OR;
          3'b111:  dec_alu = ALU_AND;
          default: dec_cls = C_ILL;
        endcase
      end
      OP_LW:  if (f3 == 3'b010) dec_cls = C_LW;
      OP_SW:  if (f3 == 3'b010) dec_cls = C_SW;
      OP_BEQ: begin
        if (f3 == 3'b000) begin
          dec_cls = C_BEQ;
          dec_alu = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  logic load_pc, pc_src, alu_src, reg_write, mem_to_reg, mem_read, mem_write;
  logic uses_imm;

  assign uses_imm = (cls_q == C_I) || (cls_q == C_LW) || (cls_q == C_SW);

  always_comb begin
    state_d    = S_IF;
    load_pc    = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: state_d = S_EX;
      S_EX: begin
        alu_src = uses_imm;
        case (cls_q)
          C_LW, C_SW: state_d = S_MEM;
          C_R, C_I:   state_d = S_WB;
          default: begin
            load_pc = 1'b1;
            pc_src  = (cls_q == C_BEQ) && bus.Zero;
          end
        endcase
      end
      S_MEM: begin
        alu_src = uses_imm;
        if (cls_q == C_LW) begin
          mem_read = 1'b1;
          state_d  = S_WB;
        end else if (cls_q == C_SW) begin
          mem_write = 1'b1;
          load_pc   = 1'b1;
        end
      end
      S_WB: begin
        alu_src    = uses_imm;
        load_pc    = 1'b1;
        reg_write  = (cls_q == C_R) || (cls_q == C_I) || (cls_q == C_LW);
        mem_to_reg = (cls_q == C_LW);
      end
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      cls_q   <= C_ILL;
      alu_q   <= ALU_AND;
      instret <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        cls_q <= dec_cls;
        alu_q <= dec_alu;
      end
      if (load_pc) instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state        = state_q;
  assign bus.loadPC   = load_pc;
  assign bus.PCSrc    = pc_src;
  assign bus.ALUSrc   = alu_src;
  assign bus.ALUCtrl  = alu_q;
  assign bus.RegWrite = reg_write;
  assign bus.MemToReg = mem_to_reg;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/strobe sequences, decode table,
// async reset (idle and mid-instruction) and instret wrap with a narrow counter.
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state   (state),
    .instret (instret)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_instret = '0;
  logic [9:0]       obs [8];
  logic [3:0]       alu_ex;
  logic [9:0]       exp_q [$];
  logic             mon_en = 1'b0;
  logic             saw_bad = 1'b0;

  // Word layout: {state[2:0], loadPC, PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite}
  function automatic logic [9:0] snap();
    return {state, bus.loadPC, bus.PCSrc, bus.ALUSrc, bus.RegWrite,
            bus.MemToReg, bus.MemRead, bus.MemWrite};
  endfunction

  always @(negedge clk) begin
    if (mon_en && (bus.RegWrite || bus.MemWrite || bus.loadPC)) saw_bad = 1'b1;
  end

  // Entered at a falling edge in IF; records n cycles plus the following IF.
  // In EX the instruction word is scrambled so a late decode would show up.
  task automatic run_instr(input logic [31:0] ins, input logic z, input int n);
    bus.instr = ins;
    bus.Zero  = z;
    alu_ex    = 4'bxxxx;
    for (int c = 0; c <= n; c++) begin
      if (c == 2) begin
        bus.instr = ins ^ 32'h0000_007F;
        #1;
      end
      obs[c] = snap();
      if (c == 2) alu_ex = bus.ALUCtrl;
      if (c < n) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr = 32'h0;
    bus.Zero  = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({snap(), bus.ALUCtrl, instret} !== 18'h0) begin
      errors++;
      $display("FAIL reset_async: got %b/%b/%h want 0000000000/0000/0", snap(), bus.ALUCtrl, instret);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({snap(), bus.ALUCtrl, instret} !== 18'h0) begin
      errors++;
      $display("FAIL reset_held: got %b/%b/%h want 0000000000/0000/0", snap(), bus.ALUCtrl, instret);
    end
    rst = 1'b1;
    exp_instret = '0;
  endtask

  task automatic test_add();
    exp_q = '{10'b000_0000000, 10'b001_0000000, 10'b010_0000000, 10'b100_1001000, 10'b000_0000000};
    run_instr(32'h002081B3, 1'b0, 4);
    for (int c = 0; c <= 4; c++) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs[c] !== e) begin
        errors++;
        $display("FAIL add_cycle%0d: got %b want %b", c, obs[c], e);
      end
    end
    exp_instret++;
    checks++;
    if ({alu_ex, instret} !== {4'b0010, exp_instret}) begin
      errors++;
      $display("FAIL add_alu_instret: got %b/%h want 0010/%h", alu_ex, instret, exp_instret);
    end
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      logic z;
      z = (k == 0);
      exp_q = '{10'b000_0000000, 10'b001_0000000, {3'b010, 1'b1, z, 5'b00000}, 10'b000_0000000};
      run_instr(32'h00208463, z, 3);
      for (int c = 0; c <= 3; c++) begin
        logic [9:0] e;
        e = exp_q.pop_front();
        checks++;
        if (obs[c] !== e) begin
          errors++;
          $display("FAIL beq_z%0d_cycle%0d: got %b want %b", z, c, obs[c], e);
        end
      end
      exp_instret++;
      checks++;
      if ({alu_ex, instret} !== {4'b0110, exp_instret}) begin
        errors++;
        $display("FAIL beq_alu_instret: got %b/%h want 0110/%h", alu_ex, instret, exp_instret);
      end
    end
  endtask

  task automatic test_mem();
    exp_q = '{10'b000_0000000, 10'b001_0000000, 10'b010_0010000, 10'b011_0010010,
              10'b100_1011100, 10'b000_0000000};
    run_instr(32'h0000A283, 1'b0, 5);
    for (int c = 0; c <= 5; c++) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs[c] !== e) begin
        errors++;
        $display("FAIL lw_cycle%0d: got %b want %b", c, obs[c], e);
      end
    end
    checks++;
    if (alu_ex !== 4'b0010) begin
      errors++;
      $display("FAIL lw_alu: got %b want 0010", alu_ex);
    end
    exp_q = '{10'b000_0000000, 10'b001_0000000, 10'b010_0010000, 10'b011_1010001, 10'b000_0000000};
    run_instr(32'h0020A223, 1'b0, 4);
    for (int c = 0; c <= 4; c++) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs[c] !== e) begin
        errors++;
        $display("FAIL sw_cycle%0d: got %b want %b", c, obs[c], e);
      end
    end
    exp_instret += 2;
    checks++;
    if ({alu_ex, instret} !== {4'b0010, exp_instret}) begin
      errors++;
      $display("FAIL sw_alu_instret: got %b/%h want 0010/%h", alu_ex, instret, exp_instret);
    end
  endtask

  task automatic test_imm_illegal();
    exp_q = '{10'b000_0000000, 10'b001_0000000, 10'b010_0010000, 10'b100_1011000, 10'b000_0000000};
    run_instr(32'h4030D093, 1'b0, 4);
    for (int c = 0; c <= 4; c++) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs[c] !== e) begin
        errors++;
        $display("FAIL srai_cycle%0d: got %b want %b", c, obs[c], e);
      end
    end
    checks++;
    if (alu_ex !== 4'b1010) begin
      errors++;
      $display("FAIL srai_alu: got %b want 1010", alu_ex);
    end
    exp_q = '{10'b000_0000000, 10'b001_0000000, 10'b010_1000000, 10'b000_0000000};
    run_instr(32'hFFFFFFFF, 1'b1, 3);
    for (int c = 0; c <= 3; c++) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs[c] !== e) begin
        errors++;
        $display("FAIL illegal_cycle%0d: got %b want %b", c, obs[c], e);
      end
    end
    exp_instret += 2;
    checks++;
    if ({alu_ex, instret} !== {4'b0010, exp_instret}) begin
      errors++;
      $display("FAIL illegal_alu_instret: got %b/%h want 0010/%h", alu_ex, instret, exp_instret);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d_ins [15] = '{32'h40000033, 32'h00001033, 32'h00002033, 32'h00004033,
                                32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033,
                                32'h00003033, 32'h40000013, 32'h00003013, 32'h00001003,
                                32'h00001063, 32'h00001023, 32'h00004013};
    logic [3:0]  d_alu [15] = '{4'b0110, 4'b1001, 4'b0111, 4'b1101, 4'b1000, 4'b1010,
                                4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                4'b0010, 4'b0010, 4'b1101};
    logic [9:0]  d_ex  [15] = '{10'b010_0000000, 10'b010_0000000, 10'b010_0000000,
                                10'b010_0000000, 10'b010_0000000, 10'b010_0000000,
                                10'b010_0000000, 10'b010_0000000, 10'b010_1000000,
                                10'b010_0010000, 10'b010_1000000, 10'b010_1000000,
                                10'b010_1000000, 10'b010_1000000, 10'b010_0010000};
    for (int i = 0; i < 15; i++) begin
      int n;
      n = (d_ex[i][6]) ? 3 : 4;
      run_instr(d_ins[i], 1'b1, n);
      exp_instret++;
      checks++;
      if ({alu_ex, obs[2], obs[n-1][6], obs[n]} !== {d_alu[i], d_ex[i], 1'b1, 10'b0}) begin
        errors++;
        $display("FAIL decode_%h: got alu=%b ex=%b lpc=%b end=%b want alu=%b ex=%b lpc=1 end=0",
                 d_ins[i], alu_ex, obs[2], obs[n-1][6], obs[n], d_alu[i], d_ex[i]);
      end
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL decode_instret: got %h want %h", instret, exp_instret);
    end
  endtask

  task automatic test_reset_mid();
    bus.instr = 32'h002081B3;
    bus.Zero  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    mon_en = 1'b1;
    #1;
    checks++;
    if ({snap(), bus.ALUCtrl, instret} !== 18'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got %b/%b/%h want 0000000000/0000/0", snap(), bus.ALUCtrl, instret);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    exp_instret = '0;
    checks++;
    if ({saw_bad, state} !== 4'b0_000) begin
      errors++;
      $display("FAIL reset_mid_abort: got saw_bad=%b state=%b want 0/000", saw_bad, state);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid_first_edge: got %b want 001", state);
    end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    exp_instret++;
    checks++;
    if ({state, instret} !== {3'b000, exp_instret}) begin
      errors++;
      $display("FAIL reset_mid_rerun: got %b/%h want 000/%h", state, instret, exp_instret);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16 && exp_instret != 4'hF; i++) begin
      case (i % 3)
        0:       run_instr(32'h0000A283, 1'b0, 5);
        1:       run_instr(32'h0020A223, 1'b0, 4);
        default: run_instr(32'h00208463, 1'b1, 3);
      endcase
      exp_instret++;
    end
    checks++;
    if ({state, instret} !== {3'b000, 4'hF}) begin
      errors++;
      $display("FAIL b2b_count: got %b/%h want 000/f", state, instret);
    end
    run_instr(32'h002081B3, 1'b0, 4);
    checks++;
    if (instret !== 4'h0) begin
      errors++;
      $display("FAIL instret_wrap: got %h want 0", instret);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_beq();
    test_mem();
    test_imm_illegal();
    test_decode();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 instr  input  32  current instruction word; stable from IF through ID.
REQ-005 Zero  input  1  ALU zero flag from datapath.
REQ-006 loadPC  output  1  one-cycle PC update strobe.
REQ-007 PCSrc  output  1  1 = take branch target, 0 = PC+4.
REQ-008 ALUSrc  output  1  1 = immediate operand, 0 = register.
REQ-009 ALUCtrl  output  4  ALU operation code.
REQ-010 RegWrite  output  1  register-file write strobe.
REQ-011 MemToReg  output  1  1 = write back dReadData, 0 = ALU result.
REQ-012 MemRead / MemWrite  output  1 each  data-memory read/write strobes.
REQ-013 state  output  3  current FSM state.
REQ-014 instret  output  CNT_W  retired-instruction count.

Function
REQ-015 FSM states: IF=000, ID=001, EX=010, MEM=011, WB=100; other codes SHALL go to IF on next edge.
REQ-016 Transitions: IF->ID->EX unconditionally; EX->MEM for lw/sw; EX->WB for R/I-type; EX->IF for beq/illegal; MEM->WB for lw; MEM->IF for sw; WB->IF.
REQ-017 Decode on ID->EX edge: latch class (R 0110011, I 0010011, LW 0000011 f3=010, SW 0100011 f3=010, BEQ 1100011 f3=000, else ILLEGAL) and ALUCtrl; hold both until next ID->EX edge; instr changes after ID SHALL have no effect.
REQ-018 ALUCtrl codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
REQ-019 R-type f3: 000 ADD (instr[30]=1: SUB), 001 SLL, 010 SLT, 100 XOR, 101 SRL (instr[30]=1: SRA), 110 OR, 111 AND; f3=011 SHALL decode ILLEGAL.
REQ-020 I-type f3: same mapping, except 000 always ADD; 011 ILLEGAL.
REQ-021 LW/SW: ALUCtrl=ADD; BEQ: SUB; ILLEGAL: ADD, no side effects.
REQ-022 ALUSrc=1 for I, LW, SW; 0 otherwise; driven from latched class, states EX..WB; 0 in IF/ID.
REQ-023 RegWrite=1 only in WB (R, I, LW); MemToReg=1 only in WB for LW.
REQ-024 MemRead=1 only in MEM for LW; MemWrite=1 only in MEM for SW.
REQ-025 loadPC=1 for exactly one cycle per instruction, in its final state: WB (R/I/LW), MEM (SW), EX (BEQ/ILLEGAL).
REQ-026 PCSrc=1 only in EX for BEQ with Zero=1 (sampled same cycle); 0 elsewhere.
REQ-027 instret increments by 1 on each edge where loadPC=1; wraps all-ones -> 0.
REQ-028 Latency: R/I 4 cycles, LW 5, SW 4, BEQ/ILLEGAL 3.

Reset
REQ-029 rst=0 SHALL immediately, regardless of clock, force state=IF, latched class=ILLEGAL, ALUCtrl=0000, instret=0, and all strobes (loadPC, PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite)=0.
REQ-030 Reset mid-instruction SHALL abort it: no RegWrite/MemWrite/loadPC for that instruction; first rising edge after rst=1 moves IF->ID.

Verification
REQ-031 instr=0x002081B3 (add x3,x1,x2) -> states IF,ID,EX,WB; ALUCtrl=0010, ALUSrc=0; RegWrite=1 and loadPC=1 only in WB; instret 0->1.
REQ-032 instr=0x00208463 (beq) with Zero=1 in EX -> PCSrc=1, loadPC=1 in EX, back to IF; repeat with Zero=0 -> PCSrc=0, loadPC=1.
REQ-033 instr=0x0000A283 (lw x5,0(x1)) -> 5 cycles; MemRead=1 in MEM; RegWrite=1, MemToReg=1 in WB; ALUSrc=1, ALUCtrl=0010.
REQ-034 instr=0x0020A223 (sw x2,4(x1)) -> MemWrite=1, loadPC=1 in MEM; RegWrite never 1; next state IF.
REQ-035 instr=0x4030D093 (srai) -> ALUCtrl=1010, ALUSrc=1; instr=0xFFFFFFFF -> 3 cycles, no RegWrite/MemRead/MemWrite, loadPC=1 in EX.
REQ-036 rst driven low mid-cycle during EX of an add -> state=000, all strobes 0, instret=0 before next edge; no RegWrite observed.
